// File: rtl/systolic_feed_ctrl.sv
// Skewed read sequencer for the banked row buffer: issues a diagonal wavefront of
// per-bank read addresses and realigns per-lane valids with the fixed memory latency.
module systolic_feed_ctrl #(
  parameter int PARALLEL_NUM = 8,
  parameter int INTER_NUM    = 8,
  parameter int ADDR_WIDTH   = $clog2(INTER_NUM),
  parameter int MEM_LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [PARALLEL_NUM-1:0] rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr [PARALLEL_NUM],
  output logic [PARALLEL_NUM-1:0] lane_valid
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | skew counter advancing, reads issued on non-stalled cycles
  // DRAIN  | last reads in flight through the memory latency
  localparam int TW   = $clog2(INTER_NUM + PARALLEL_NUM);
  localparam int DW   = $clog2(MEM_LATENCY + 1);
  localparam int LAST = INTER_NUM + PARALLEL_NUM - 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  state;
  logic [TW-1:0]           t;
  logic [DW-1:0]           drain_cnt;
  logic [PARALLEL_NUM-1:0] vpipe [MEM_LATENCY];
  logic [PARALLEL_NUM-1:0] active;
  int                      t_i;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      t         <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            t     <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (t == TW'(LAST)) begin
              state     <= S_DRAIN;
              drain_cnt <= DW'(MEM_LATENCY);
            end else begin
              t <= t + TW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(1)) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign t_i  = int'(t);
  assign busy = (state != S_IDLE);

  // Lane i trails lane 0 by i cycles, so its address is simply t - i while in window.
  always_comb begin
    active = '0;
    rd_en  = '0;
    for (int i = 0; i < PARALLEL_NUM; i++) begin
      active[i]  = (t_i >= i) && (t_i <= i + INTER_NUM - 1);
      rd_en[i]   = (state == S_RUN) && !stall && active[i];
      rd_addr[i] = active[i] ? ADDR_WIDTH'(t_i - i) : '0;
    end
  end

  // Free-running delay line: stalls become valid bubbles rather than lost reads.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < MEM_LATENCY; k++) vpipe[k] <= '0;
    end else begin
      vpipe[0] <= rd_en;
      for (int k = 1; k < MEM_LATENCY; k++) vpipe[k] <= vpipe[k-1];
    end
  end

  assign lane_valid = vpipe[MEM_LATENCY-1];

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: default 8/8/2 instance plus a 2/4/1 corner instance,
// checked cycle by cycle against a wavefront model built from the sweep rules.
module tb_systolic_feed_ctrl;

  localparam int MAXC = 128;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start_a = 1'b0, stall_a = 1'b0;
  logic start_b = 1'b0, stall_b = 1'b0;

  logic       busy_a, done_a;
  logic [7:0] rd_en_a, lane_valid_a;
  logic [2:0] rd_addr_a [8];
  logic       busy_b, done_b;
  logic [1:0] rd_en_b, lane_valid_b;
  logic [1:0] rd_addr_b [2];

  systolic_feed_ctrl dut_a (
    .clk(clk), .nrst(nrst), .start(start_a), .stall(stall_a),
    .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .lane_valid(lane_valid_a)
  );

  systolic_feed_ctrl #(.PARALLEL_NUM(2), .INTER_NUM(4), .MEM_LATENCY(1)) dut_b (
    .clk(clk), .nrst(nrst), .start(start_b), .stall(stall_b),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .lane_valid(lane_valid_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic        g_busy, g_done;
  logic [7:0]  g_en, g_valid;
  logic [31:0] g_addr;

  always_comb begin
    g_busy = 1'b0; g_done = 1'b0; g_en = '0; g_valid = '0; g_addr = '0;
    if (sel == 0) begin
      g_busy = busy_a; g_done = done_a; g_en = rd_en_a; g_valid = lane_valid_a;
      for (int i = 0; i < 8; i++) g_addr[4*i +: 4] = {1'b0, rd_addr_a[i]};
    end else begin
      g_busy = busy_b; g_done = done_b; g_en = {6'b0, rd_en_b}; g_valid = {6'b0, lane_valid_b};
      for (int i = 0; i < 2; i++) g_addr[4*i +: 4] = {2'b0, rd_addr_b[i]};
    end
  end

  bit          start_m [MAXC];
  bit          stall_m [MAXC];
  bit          exp_busy [MAXC];
  bit          exp_done [MAXC];
  bit          exp_run [MAXC];
  int          tval [MAXC];
  logic [7:0]  exp_en [MAXC];
  logic [7:0]  exp_valid [MAXC];
  logic [31:0] exp_addr [MAXC];
  int          seen [8][8];

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      start_m[k] = 0;
      stall_m[k] = 0;
    end
  endtask

  // Cycle c is the interval after edge c-1; a start sampled at edge e launches a sweep
  // whose wavefront position p advances once per non-stalled RUN cycle from 0 to LAST.
  task automatic build_expected(input int pn, input int inn, input int ml);
    int last, idle_at, c, p;
    last = inn + pn - 2;
    idle_at = 0;
    for (int k = 0; k < MAXC; k++) begin
      exp_busy[k] = 0; exp_done[k] = 0; exp_run[k] = 0; tval[k] = 0;
      exp_en[k] = '0; exp_valid[k] = '0; exp_addr[k] = '0;
    end
    for (int e = 1; e < MAXC; e++) begin
      if (start_m[e] && e >= idle_at) begin
        c = e + 1;
        p = 0;
        while (p <= last && c < MAXC) begin
          exp_busy[c] = 1;
          exp_run[c]  = 1;
          tval[c]     = p;
          if (!stall_m[c]) p++;
          c++;
        end
        for (int k = c; k < MAXC; k++) tval[k] = last;
        for (int d = 0; d < ml && c < MAXC; d++) begin
          exp_busy[c] = 1;
          c++;
        end
        if (c < MAXC) exp_done[c] = 1;
        idle_at = c;
      end
    end
    for (int k = 0; k < MAXC; k++)
      for (int i = 0; i < pn; i++)
        if (tval[k] >= i && tval[k] <= i + inn - 1) begin
          exp_addr[k][4*i +: 4] = 4'(tval[k] - i);
          if (exp_run[k] && !stall_m[k]) exp_en[k][i] = 1'b1;
        end
    for (int k = ml; k < MAXC; k++) exp_valid[k] = exp_en[k-ml];
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    start_a = 0; stall_a = 0; start_b = 0; stall_b = 0;
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic run_scenario(input string tag, input int n);
    int pn, inn, ml, a;
    pn  = (sel == 0) ? 8 : 2;
    inn = (sel == 0) ? 8 : 4;
    ml  = (sel == 0) ? 2 : 1;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) seen[i][j] = 0;
    apply_reset();
    build_expected(pn, inn, ml);
    for (int c = 1; c <= n; c++) begin
      if (sel == 0) begin start_a = start_m[c]; stall_a = stall_m[c]; end
      else begin start_b = start_m[c]; stall_b = stall_m[c]; end
      @(negedge clk);
      checks++;
      if (g_busy !== exp_busy[c]) begin
        failures++;
        $display("FAIL %s busy c=%0d got=%b exp=%b", tag, c, g_busy, exp_busy[c]);
      end
      checks++;
      if (g_done !== exp_done[c]) begin
        failures++;
        $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, g_done, exp_done[c]);
      end
      checks++;
      if (g_en !== exp_en[c]) begin
        failures++;
        $display("FAIL %s rd_en c=%0d got=%h exp=%h", tag, c, g_en, exp_en[c]);
      end
      checks++;
      if (g_valid !== exp_valid[c]) begin
        failures++;
        $display("FAIL %s lane_valid c=%0d got=%h exp=%h", tag, c, g_valid, exp_valid[c]);
      end
      checks++;
      if (g_addr !== exp_addr[c]) begin
        failures++;
        $display("FAIL %s rd_addr c=%0d got=%h exp=%h", tag, c, g_addr, exp_addr[c]);
      end
      for (int i = 0; i < 8; i++) begin
        a = int'(g_addr[4*i +: 4]);
        if (g_en[i] === 1'b1 && a < 8) seen[i][a]++;
      end
      @(posedge clk);
      #1;
    end
    start_a = 0; stall_a = 0; start_b = 0; stall_b = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy_a, done_a, rd_en_a, lane_valid_a} !== '0 ||
        {busy_b, done_b, rd_en_b, lane_valid_b} !== '0) begin
      failures++;
      $display("FAIL %s ctrl got a=%b%b/%h/%h b=%b%b/%h/%h exp=0", tag, busy_a, done_a,
               rd_en_a, lane_valid_a, busy_b, done_b, rd_en_b, lane_valid_b);
    end
    checks++;
    if ({rd_addr_a[0], rd_addr_a[1], rd_addr_a[2], rd_addr_a[3], rd_addr_a[4], rd_addr_a[5],
         rd_addr_a[6], rd_addr_a[7], rd_addr_b[0], rd_addr_b[1]} !== '0) begin
      failures++;
      $display("FAIL %s rd_addr got nonzero exp=0", tag);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    nrst = 1'b0;
    #3;
    check_all_zero("reset_held");
    clear_stim();
    run_scenario("reset_idle", 20);
  endtask

  task automatic test_single_sweep();
    sel = 0;
    clear_stim();
    start_m[1] = 1;
    run_scenario("single", 24);
  endtask

  task automatic test_stall();
    sel = 0;
    clear_stim();
    start_m[1] = 1;
    for (int c = 6; c <= 8; c++) stall_m[c] = 1;
    run_scenario("stall", 26);
    for (int i = 0; i < 8; i++) begin
      int bad;
      bad = 0;
      for (int j = 0; j < 8; j++) if (seen[i][j] != 1) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL stall_bank_coverage bank=%0d got=%0d addrs not seen once exp=0", i, bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    clear_stim();
    start_m[1]  = 1;
    start_m[4]  = 1;
    start_m[17] = 1;
    start_m[19] = 1;
    run_scenario("back_to_back", 42);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    clear_stim();
    start_m[1] = 1;
    run_scenario("mid_pre", 10);
    #2 nrst = 1'b0;
    #1;
    check_all_zero("reset_mid");
    clear_stim();
    start_m[1] = 1;
    run_scenario("after_reset", 24);
  endtask

  task automatic test_corner();
    sel = 1;
    clear_stim();
    start_m[1] = 1;
    run_scenario("corner", 12);
    clear_stim();
    start_m[1] = 1;
    start_m[3] = 1;
    stall_m[4] = 1;
    start_m[9] = 1;
    run_scenario("corner_b2b", 20);
    sel = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      sel = (it == 4) ? 1 : 0;
      clear_stim();
      start_m[1] = 1;
      for (int c = 2; c <= 70; c++) begin
        stall_m[c] = ($urandom_range(3) == 0);
        start_m[c] = ($urandom_range(7) == 0);
      end
      run_scenario("random", 70);
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_corner();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for the banked matrix row buffer. On a start pulse it issues skewed per-bank read addresses so that bank i begins i cycles after bank 0, which produces the diagonal wavefront a systolic array needs. It also tracks fixed memory read latency to raise per-lane valids, supports a downstream stall, and reports completion with a done pulse. It sits between the layer-level control FSM and the PARALLEL_NUM row memories.

## Interface

- PARALLEL_NUM, 8: number of banks/lanes; must be ≥ 2.
- INTER_NUM, 8: rows per bank (bank depth); must be ≥ 2.
- ADDR_WIDTH, $clog2(INTER_NUM): bank address width.
- MEM_LATENCY, 2: cycles from read issue to data at memory output; must be ≥ 1.
- clk  in  1  single clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a sweep if sampled in IDLE, ignored otherwise.
- stall  in  1  downstream not ready; freezes read issue in RUN.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, registered, after the sweep completes.
- rd_en  out  PARALLEL_NUM  per-bank read enable.
- rd_addr  out  ADDR_WIDTH × PARALLEL_NUM (unpacked)  per-bank read address.
- lane_valid  out  PARALLEL_NUM  per-lane data valid, aligned with memory output.

## Operation

- States: IDLE, RUN, DRAIN.
  - IDLE→RUN when start=1.
  - RUN→DRAIN at the edge where t = LAST and stall=0.
  - DRAIN→IDLE after MEM_LATENCY cycles in DRAIN.
- Skew counter t: width $clog2(INTER_NUM+PARALLEL_NUM), range 0..LAST, where LAST = INTER_NUM+PARALLEL_NUM-2.
  - Cleared on IDLE→RUN.
  - Increments on every RUN edge with stall=0.
  - Holds when stall=1.
- Lane i is active when i ≤ t ≤ i+INTER_NUM-1.
- rd_en[i] = (state==RUN) & ~stall & active(i). This path is combinational from state, t and stall.
- rd_addr[i] = (t − i) truncated to ADDR_WIDTH when lane i is active, else 0.
- lane_valid[i] = rd_en[i] delayed by exactly MEM_LATENCY cycles through a shift register.
  - The shift register always shifts, including during stall and DRAIN.
  - Stalled cycles therefore produce valid bubbles, and no issued read is lost.
- Drain counter: width $clog2(MEM_LATENCY+1). Loaded on entry to DRAIN. stall is ignored in DRAIN.
- done is set on the DRAIN→IDLE edge and cleared on the next edge.
- A start sampled while done=1 (state IDLE) is accepted, giving back-to-back sweeps.
- start while busy=1 is dropped and is not queued.
- Reset (async, any time): state=IDLE, t=0, drain counter=0, valid pipeline cleared, done=0. In-flight valids are discarded.
- Reset values of outputs: busy=0, done=0, rd_en=0, rd_addr all 0, lane_valid=0.

## Timing

- Cycles are numbered relative to edge E, at which start is sampled high in IDLE. "Cycle E+k" is the interval after edge E+k.
- With no stall, RUN occupies cycles E+1..E+LAST+1 and t = k−1.
  - Lane i issues addresses 0..INTER_NUM-1 during cycles E+1+i..E+i+INTER_NUM.
  - lane_valid[i] is high during cycles E+1+i+MEM_LATENCY..E+i+INTER_NUM+MEM_LATENCY.
- Defaults (8/8/2):
  - RUN: cycles E+1..E+15.
  - DRAIN: cycles E+16..E+17.
  - Last lane_valid[7]: cycle E+17.
  - done=1 and busy=0: cycle E+18.
  - Total sweep latency from start to done: 18 cycles.
- Each stall cycle in RUN extends every later event by one cycle.
- busy rises in the cycle after start is sampled and falls in the same cycle that done rises.

## Test plan

- **Reset, no start:** assert nrst=0, release, idle 20 cycles → busy=0, done=0, rd_en=0, lane_valid=0 throughout.
- **Single sweep (8/8/2):** one start pulse at E → the following must all hold:
  - rd_en[0] high at E+1..E+8 with rd_addr[0]=0..7.
  - rd_en[7] high at E+8..E+15 with rd_addr[7]=0..7.
  - lane_valid[i] equals rd_en[i] shifted by 2 cycles.
  - done high only at E+18.
- **Stall mid-sweep:** stall=1 for cycles E+5..E+7 → the following must all hold:
  - rd_en=0 and t holds at 4 during the stall.
  - lane_valid shows a 3-cycle gap starting at E+7.
  - Every bank still receives addresses 0..7 exactly once.
  - done at E+21.
- **Start while busy, and back-to-back:**
  - Extra start pulses at E+3 and E+16 → ignored; exactly one done, at E+18.
  - start sampled at E+18, when done=1 → a second sweep with done at E+36.
- **Reset mid-operation:** nrst=0 at E+10 (asynchronous, mid-cycle) → all outputs 0 immediately. After release, a new start produces a full, correct sweep.
- **Parameter corner (PARALLEL_NUM=2, INTER_NUM=4, MEM_LATENCY=1):** start at E → the following must all hold:
  - LAST=4.
  - Lane 1 addresses 0..3 at E+2..E+5.
  - lane_valid[1] at E+3..E+6.
  - done at E+7.
